rv32m_seq_fu: RTL and testbench
===============================

# rv32m_seq_fu

Sequential RV32M execute unit that sits directly downstream of the RV32M decoder. It accepts the decoder's `rv32m_decode_t` (select + op) together with the two register operands. It computes MUL/MULH/MULHSU/MULHU by radix-2 shift-add and DIV/DIVU/REM/REMU by radix-2 restoring division, then returns a 32-bit result to the execute-stage writeback mux with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `decode`  in  `rv32m_decode_t`  `select` requests an operation; `op` selects it.
- `rs1_data`  in  32  dividend / multiplicand.
- `rs2_data`  in  32  divisor / multiplier.
- `kill`  in  1  pipeline flush; aborts any in-flight operation.
- `busy`  out  1  high while an operation is in progress and the result has not yet been presented.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  registered result; held until the next `done`.

## Operation
- States: IDLE, RUN, FINISH.
- `start` = `decode.select & ~kill`. It is accepted in IDLE and in FINISH, which allows back-to-back operations. It is ignored in RUN.
- On accept, latch the following:
  - op;
  - |rs1| and |rs2| for signed operand positions;
  - the result sign;
  - counter = 31.
- Result sign:
  - MULH: rs1[31]^rs2[31].
  - MULHSU: rs1[31] (rs2 is unsigned).
  - DIV: rs1[31]^rs2[31].
  - REM: rs1[31].
  - Unsigned ops: 0.
- MUL uses the signed path; the low word is sign-invariant.
- Multiply, per RUN cycle: if multiplier LSB is set, add the multiplicand into the upper half of a 64-bit accumulator; then shift right one bit. After the final iteration, conditionally negate the 64-bit product. MUL returns [31:0]; MULH* return [63:32].
- Divide, per RUN cycle: shift {remainder, quotient} left one bit, trial-subtract the divisor, and keep the difference if it is non-negative. After the final iteration, conditionally negate the quotient and the remainder independently.
- RUN → FINISH when the counter reaches 0. `result` is loaded on that same edge.
- Special cases are decided in IDLE/FINISH at accept time and go straight to FINISH:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed overflow, DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- FINISH → IDLE when no new start is accepted.
- `kill` in any state forces IDLE on the next edge. No `done` is produced and `result` is unchanged.
- `kill` together with `select` in the same cycle: kill wins and the request is not accepted.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, all datapath registers 0.
- `done` = (state == FINISH).
- `busy` = (state == RUN), or a start being accepted this cycle.
- Normal latency, with start sampled at edge t:
  - RUN occupies cycles t+1 … t+32;
  - `done` is high in cycle t+33.
- Special-case latency: `done` is high in cycle t+1.
- Back-to-back: a start accepted during FINISH enters RUN the next cycle. `done` pulses exactly once per operation.
- Reset asserted mid-operation immediately returns all outputs to their reset values. No `done` is produced for the aborted operation.

## Structure
- The following belong in `rv32m_pkg` alongside the existing decode types:
  - `rv32m_fu_state_t` (IDLE/RUN/FINISH enum);
  - localparam `RV32M_ITERATIONS = 32`;
  - localparams for the divide-by-zero and overflow constants.
- One sub-module is natural: `rv32m_radix2_core`. It holds the shared 64-bit shift register, the 33-bit adder/subtractor and the iteration counter, selected by a mul/div mode bit.
- The top level keeps the FSM, the sign/abs pre-processing, the special-case detection, and the post-negation/result select.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB with `done` in cycle t+33. MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU of the same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, REMU 5 % 0 → 5, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. Each has `done` in cycle t+1.
- `kill` at t+10 of a DIV → no `done`, `busy` low at t+11, `result` unchanged. A new MUL started at t+11 completes correctly at t+44.
- `nRST` deasserted-low at t+5 of a MULHU → all outputs reset within the same cycle. After release, a start returns the correct result. A start held high during RUN is ignored.

Source files
------------

// File: rtl/rv32m_seq_fu_pkg.sv
// Shared RV32M types: decoder output, FU state encoding and the fixed
// constants used by the sequential multiply/divide unit.
package rv32m_pkg;

   localparam int XLEN             = 32;
   localparam int RV32M_ITERATIONS = 32;
   localparam int RV32M_CNT_W      = $clog2(RV32M_ITERATIONS);

   // Results defined by the ISA for the two divide corner cases.
   localparam logic [31:0] RV32M_DIV0_QUOTIENT = 32'hFFFF_FFFF;
   localparam logic [31:0] RV32M_OVF_DIVIDEND  = 32'h8000_0000;
   localparam logic [31:0] RV32M_OVF_DIVISOR   = 32'hFFFF_FFFF;
   localparam logic [31:0] RV32M_OVF_QUOTIENT  = 32'h8000_0000;
   localparam logic [31:0] RV32M_OVF_REMAINDER = 32'h0000_0000;

   // Encoding follows funct3 of the RV32M instructions.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } rv32m_op_t;

   typedef struct packed {
      logic      select;
      rv32m_op_t op;
   } rv32m_decode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } rv32m_fu_state_t;

   function automatic logic is_div_op(rv32m_op_t op);
      return op[2];
   endfunction

   function automatic logic is_rem_op(rv32m_op_t op);
      return op[2] & op[1];
   endfunction

   // Magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(logic [31:0] x);
      return x[31] ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/rv32m_seq_fu_if.sv
// Request/response bundle between the execute stage and the RV32M unit.
interface rv32m_seq_fu_if
   import rv32m_pkg::*;
();
   rv32m_decode_t decode;
   logic [31:0]   rs1_data;
   logic [31:0]   rs2_data;
   logic          kill;
   logic          busy;
   logic          done;
   logic [31:0]   result;

   modport master (
      output decode, rs1_data, rs2_data, kill,
      input  busy, done, result
   );

   modport slave (
      input  decode, rs1_data, rs2_data, kill,
      output busy, done, result
   );
endinterface

// File: rtl/rv32m_seq_fu_radix2_core.sv
// Radix-2 iteration engine shared by multiply (shift-add) and divide
// (restoring). Works on unsigned magnitudes; signs are handled outside.
module rv32m_radix2_core
   import rv32m_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        load,
   input  logic        div_mode,
   input  logic [31:0] acc_lo_init,  // multiplier or dividend
   input  logic [31:0] b_init,       // multiplicand or divisor
   input  logic        step,
   output logic [63:0] acc_nxt,      // accumulator after this cycle's iteration
   output logic        last
);

   logic                   mode_q;
   logic [63:0]            acc_q;
   logic [31:0]            b_q;
   logic [RV32M_CNT_W-1:0] cnt_q;

   logic [33:0] op_a;
   logic [33:0] op_b;
   logic [33:0] addsub;

   // One shared adder: multiply adds into the high word, divide
   // trial-subtracts from the 33-bit shifted remainder.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      acc_nxt = acc_q;
      op_a    = mode_q ? {1'b0, acc_q[63:31]} : {2'b00, acc_q[63:32]};
      op_b    = {2'b00, b_q};
      addsub  = mode_q ? (op_a - op_b) : (op_a + op_b);
      if (mode_q) begin
         // Borrow out means the trial difference went negative: restore.
         acc_nxt = addsub[33] ? {acc_q[62:0], 1'b0}
                              : {addsub[31:0], acc_q[30:0], 1'b1};
      end else begin
         acc_nxt = acc_q[0] ? {addsub[32:0], acc_q[31:1]}
                            : {1'b0, acc_q[63:1]};
      end
   end

   assign last = (cnt_q == '0);

   // Operand load on accept, then one iteration per step.
   always_ff @(posedge CLK or negedge nRST) begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      if (!nRST) begin
         mode_q <= 1'b0;
         acc_q  <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         mode_q <= div_mode;
         acc_q  <= {32'd0, acc_lo_init};
         b_q    <= b_init;
         cnt_q  <= RV32M_CNT_W'(RV32M_ITERATIONS - 1);
      end else if (step) begin
         acc_q  <= acc_nxt;
         cnt_q  <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/rv32m_seq_fu.sv
// Sequential RV32M execute unit: FSM, sign/magnitude pre-processing,
// divide corner-case shortcuts and result post-negation/select.
module rv32m_seq_fu
   import rv32m_pkg::*;
(
   input  logic           CLK,
   input  logic           nRST,
   rv32m_seq_fu_if.slave  fu
);

   rv32m_fu_state_t state_q;
   rv32m_op_t       op_q;
   logic            neg_q;
   logic [31:0]     result_q;

   rv32m_op_t   op_in;
   logic        start;
   logic        accept;
   logic        signed1;
   logic        signed2;
   logic        neg_in;
   logic        div_in;
   logic        div_zero;
   logic        div_ovf;
   logic        special;
   logic [31:0] special_val;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] core_lo;
   logic [31:0] core_b;
   logic [63:0] core_acc;
   logic        core_last;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] fin_val;

   assign op_in  = fu.decode.op;
   assign start  = fu.decode.select & ~fu.kill;
   assign accept = start & (state_q != RUN);

   // Operand magnitudes, result sign and divide shortcuts for the request.
   always_comb begin
      signed1 = 1'b0;
      signed2 = 1'b0;
      neg_in  = 1'b0;
      case (op_in)
         OP_MUL, OP_MULH, OP_DIV: begin
            signed1 = 1'b1;
            signed2 = 1'b1;
            neg_in  = fu.rs1_data[31] ^ fu.rs2_data[31];
         end
         OP_MULHSU: begin
            signed1 = 1'b1;
            neg_in  = fu.rs1_data[31];
         end
         OP_REM: begin
            signed1 = 1'b1;
            signed2 = 1'b1;
            neg_in  = fu.rs1_data[31];
         end
         default: ;
      endcase

      mag1     = signed1 ? abs32(fu.rs1_data) : fu.rs1_data;
      mag2     = signed2 ? abs32(fu.rs2_data) : fu.rs2_data;
      div_in   = is_div_op(op_in);
      div_zero = div_in & (fu.rs2_data == 32'd0);
      div_ovf  = div_in & signed2 & (fu.rs1_data == RV32M_OVF_DIVIDEND)
                        & (fu.rs2_data == RV32M_OVF_DIVISOR);
      special  = div_zero | div_ovf;

      special_val = 32'd0;
      if (div_zero)
         special_val = is_rem_op(op_in) ? fu.rs1_data : RV32M_DIV0_QUOTIENT;
      else if (div_ovf)
         special_val = is_rem_op(op_in) ? RV32M_OVF_REMAINDER : RV32M_OVF_QUOTIENT;

      // Divide keeps the dividend in the low half; multiply shifts the
      // multiplier out of the low half.
      core_lo = div_in ? mag1 : mag2;
      core_b  = div_in ? mag2 : mag1;
   end

   rv32m_radix2_core u_core (
      .CLK         (CLK),
      .nRST        (nRST),
      .load        (accept & ~special),
      .div_mode    (div_in),
      .acc_lo_init (core_lo),
      .b_init      (core_b),
      .step        (state_q == RUN),
      .acc_nxt     (core_acc),
      .last        (core_last)
   );

   // Final sign correction and word select, taken from the last iteration.
   always_comb begin
      prod = neg_q ? (64'd0 - core_acc) : core_acc;
      quo  = core_acc[31:0];
      rem  = core_acc[63:32];
      case (op_q)
         OP_MUL:                       fin_val = prod[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod[63:32];
         OP_DIV, OP_DIVU:              fin_val = neg_q ? (32'd0 - quo) : quo;
         default:                      fin_val = neg_q ? (32'd0 - rem) : rem;
      endcase
   end

   // Control FSM; kill has priority over everything except reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (fu.kill) begin
         state_q  <= IDLE;
      end else begin
         case (state_q)
            IDLE, FINISH: begin
               if (accept) begin
                  op_q  <= op_in;
                  neg_q <= neg_in;
                  if (special) begin
                     state_q  <= FINISH;
                     result_q <= special_val;
                  end else begin
                     state_q  <= RUN;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (core_last) begin
                  state_q  <= FINISH;
                  result_q <= fin_val;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fu.busy   = (state_q == RUN) | accept;
   assign fu.done   = (state_q == FINISH);
   assign fu.result = result_q;

endmodule

// File: tb/tb_rv32m_seq_fu.sv
// Directed bench for rv32m_seq_fu: vector table plus kill/reset/back-to-back sequences.
module tb_rv32m_seq_fu;
   import rv32m_pkg::*;

   logic clk;
   logic rst_n;

   rv32m_seq_fu_if fu_if ();

   rv32m_seq_fu dut (
      .CLK  (clk),
      .nRST (rst_n),
      .fu   (fu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      rv32m_op_t   op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t        vq[$];
   int          n_vec;
   int          n_bad;
   logic [31:0] last_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input rv32m_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vq.push_back(v);
   endtask

   // Present one request, measure cycles to done, check result and single pulse.
   task automatic run_op(input vec_t v);
      int   lat;
      logic got;
      fu_if.decode.op     = v.op;
      fu_if.rs1_data      = v.a;
      fu_if.rs2_data      = v.b;
      fu_if.decode.select = 1'b1;
      @(posedge clk); #1;
      fu_if.decode.select = 1'b0;
      got = 1'b0;
      for (lat = 1; lat <= 40; lat++) begin
         if (lat > 1) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         if (lat == 1) check({v.name, " busy@t+1"}, 32'(fu_if.busy), 32'(v.lat > 1));
         if (fu_if.done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) lat = -1;
      check({v.name, " latency"}, 32'(lat), 32'(v.lat));
      check({v.name, " result"}, fu_if.result, v.exp);
      @(posedge clk); #1;
      @(negedge clk);
      check({v.name, " done once"}, 32'(fu_if.done), 32'd0);
      last_exp = v.exp;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t v;
      logic ok;
      int   n_done;
      int   done_cyc[2];
      logic [31:0] done_res[2];

      n_vec = 0;
      n_bad = 0;
      last_exp = '0;

      add("MUL 7*-3",          OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      add("MULH min*min",      OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      add("MULHSU -1*max",     OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      add("MULHU max*max",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      add("DIV -7/2",          OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
      add("REM -7%2",          OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      add("DIVU 100/7",        OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
      add("REMU 100%7",        OP_REMU,   32'd100,       32'd7,         32'd2,         33);
      add("DIVU 5/0",          OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      add("REMU 5%0",          OP_REMU,   32'd5,         32'd0,         32'd5,         1);
      add("DIV ovf",           OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      add("REM ovf",           OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      add("DIV 0/0",           OP_DIV,    32'd0,         32'd0,         32'hFFFF_FFFF, 1);
      add("REM -7%0",          OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
      add("MUL shift",         OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
      add("MULHU max*2",       OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33);
      add("MULH -1*-1",        OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      add("MULH -1*2",         OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      add("DIV 7/-2",          OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      add("REM 7%-2",          OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33);
      add("DIVU max/1",        OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
      add("REMU max%min",      OP_REMU,   32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
      add("DIVU max/max-1",    OP_DIVU,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      add("REMU max%max-1",    OP_REMU,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);

      // Reset
      rst_n               = 1'b0;
      fu_if.decode.select = 1'b0;
      fu_if.decode.op     = OP_MUL;
      fu_if.rs1_data      = '0;
      fu_if.rs2_data      = '0;
      fu_if.kill          = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy",   32'(fu_if.busy), 32'd0);
      check("reset done",   32'(fu_if.done), 32'd0);
      check("reset result", fu_if.result,    32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vq[i]) run_op(vq[i]);

      // kill together with select: request must not be accepted
      fu_if.decode.op     = OP_MUL;
      fu_if.rs1_data      = 32'd3;
      fu_if.rs2_data      = 32'd3;
      fu_if.decode.select = 1'b1;
      fu_if.kill          = 1'b1;
      #1;
      check("kill+select busy", 32'(fu_if.busy), 32'd0);
      @(posedge clk); #1;
      fu_if.decode.select = 1'b0;
      fu_if.kill          = 1'b0;
      @(negedge clk);
      check("kill+select idle busy", 32'(fu_if.busy), 32'd0);
      check("kill+select idle done", 32'(fu_if.done), 32'd0);
      @(posedge clk); #1;

      // kill at t+10 of a DIV, then a MUL started at t+11
      fu_if.decode.op     = OP_DIV;
      fu_if.rs1_data      = 32'd100;
      fu_if.rs2_data      = 32'd7;
      fu_if.decode.select = 1'b1;
      @(posedge clk); #1;
      fu_if.decode.select = 1'b0;
      ok = 1'b1;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (fu_if.done) ok = 1'b0;
         @(posedge clk); #1;
      end
      fu_if.kill = 1'b1;
      @(negedge clk);
      if (fu_if.done) ok = 1'b0;
      @(posedge clk); #1;
      fu_if.kill = 1'b0;
      @(negedge clk);
      check("kill no done",     32'(ok),         32'd1);
      check("kill busy t+11",   32'(fu_if.busy), 32'd0);
      check("kill done t+11",   32'(fu_if.done), 32'd0);
      check("kill result held", fu_if.result,    last_exp);
      v.name = "MUL after kill"; v.op = OP_MUL;
      v.a = 32'h0000_1001; v.b = 32'h0000_0101; v.exp = 32'h0010_1101; v.lat = 33;
      run_op(v);

      // reset asserted at t+5 of a MULHU
      fu_if.decode.op     = OP_MULHU;
      fu_if.rs1_data      = 32'hFFFF_FFFF;
      fu_if.rs2_data      = 32'hFFFF_FFFF;
      fu_if.decode.select = 1'b1;
      @(posedge clk); #1;
      fu_if.decode.select = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-reset busy",   32'(fu_if.busy), 32'd0);
      check("mid-reset done",   32'(fu_if.done), 32'd0);
      check("mid-reset result", fu_if.result,    32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (fu_if.done || fu_if.busy) ok = 1'b0;
      end
      check("post-reset quiet", 32'(ok), 32'd1);
      @(posedge clk); #1;
      v.name = "MULHU after reset"; v.op = OP_MULHU;
      v.a = 32'hFFFF_FFFF; v.b = 32'hFFFF_FFFF; v.exp = 32'hFFFF_FFFE; v.lat = 33;
      run_op(v);

      // select held through RUN is ignored; re-accepted in FINISH (back-to-back)
      fu_if.decode.op     = OP_MUL;
      fu_if.rs1_data      = 32'd3;
      fu_if.rs2_data      = 32'd5;
      fu_if.decode.select = 1'b1;
      @(posedge clk); #1;
      fu_if.rs1_data = 32'd9;
      n_done = 0;
      done_cyc[0] = -1; done_cyc[1] = -1;
      done_res[0] = '0; done_res[1] = '0;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (c == 33) check("b2b busy in FINISH", 32'(fu_if.busy), 32'd1);
         if (fu_if.done) begin
            if (n_done < 2) begin
               done_cyc[n_done] = c;
               done_res[n_done] = fu_if.result;
            end
            n_done++;
         end
         @(posedge clk); #1;
         if (c == 33) fu_if.decode.select = 1'b0;
      end
      check("b2b done count",   32'(n_done),      32'd2);
      check("b2b first cycle",  32'(done_cyc[0]), 32'd33);
      check("b2b first result", done_res[0],      32'd15);
      check("b2b second cycle", 32'(done_cyc[1]), 32'd66);
      check("b2b second result", done_res[1],     32'd45);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
